// File: rtl/text_line_writer_if.sv
// Producer-side glyph stream for text_line_writer: valid/ready glyph handshake
// plus commit/clear control and the pending-commit status flag.
interface text_line_writer_if;
  logic [9:0] char_in;
  logic       char_valid;
  logic       char_ready;
  logic       commit;
  logic       clear;
  logic       busy;

  modport master (
    output char_in,
    output char_valid,
    output commit,
    output clear,
    input  char_ready,
    input  busy
  );

  modport slave (
    input  char_in,
    input  char_valid,
    input  commit,
    input  clear,
    output char_ready,
    output busy
  );
endinterface

// File: rtl/text_line_writer.sv
// Double-buffered single-line text source for the VGA overlay; glyphs fill a back bank,
// which is swapped to the front at a frame boundary. Optional blink: define TEXT_BLINK_EN.
module text_line_writer #(
  parameter int MAX_CHARS = 16,
  parameter int X_START   = 0,
  parameter int Y_START   = 0,
  parameter int FONT_W    = 8,
  parameter int FONT_H    = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  text_line_writer_if.slave    prod,
  input  logic                 frame_start,
  input  logic                 blink,
  input  logic [9:0]           DrawX,
  input  logic [9:0]           DrawY,
  input  logic                 active,
  output logic [9:0]           start_x,
  output logic [9:0]           start_y,
  output logic [9:0]           n,
  output logic                 is_word
);

  localparam int         IDX_W   = (MAX_CHARS > 1) ? $clog2(MAX_CHARS) : 1;
  localparam int         FONT_SH = $clog2(FONT_W);
  localparam logic [5:0] MAX_LEN = 6'(MAX_CHARS);
  localparam logic [9:0] X0      = 10'(X_START);
  localparam logic [9:0] Y0      = 10'(Y_START);
  localparam logic [9:0] FH      = 10'(FONT_H);

  typedef enum logic [0:0] {
    S_FILL = 1'b0,
    S_PEND = 1'b1
  } state_t;

  state_t     r_state;
  logic       r_sel;
  logic [5:0] r_wr_len;
  logic [5:0] r_fr_len;
  logic       r_busy;
  logic [9:0] r_bank [0:1][0:MAX_CHARS-1];

  logic             w_ready;
  logic             w_accept;
  logic             w_blink_ok;
  logic [10:0]      w_xdiff;
  logic [10:0]      w_ydiff;
  logic [10:0]      w_xlim;
  logic [IDX_W-1:0] w_col;
  logic             w_in_x;
  logic             w_in_y;
  logic             w_hit;

  assign w_ready  = Reset && (r_state == S_FILL) && (r_wr_len < MAX_LEN);
  // clear wins over a same-cycle handshake, so the offered glyph is dropped
  assign w_accept = prod.char_valid && w_ready && !prod.clear;

  assign prod.char_ready = w_ready;
  assign prod.busy       = r_busy;
  assign start_x         = X0;
  assign start_y         = Y0;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state  <= S_FILL;
      r_sel    <= 1'b0;
      r_wr_len <= 6'd0;
      r_fr_len <= 6'd0;
      r_busy   <= 1'b0;
    end else if (prod.clear) begin
      r_state  <= S_FILL;
      r_wr_len <= 6'd0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        S_FILL: begin
          if (w_accept) begin
            r_wr_len <= r_wr_len + 6'd1;
          end
          // frame_start here is ignored: the swap waits for the next pulse
          if (prod.commit) begin
            r_state <= S_PEND;
            r_busy  <= 1'b1;
          end
        end
        S_PEND: begin
          if (frame_start) begin
            r_sel    <= ~r_sel;
            r_fr_len <= r_wr_len;
            r_wr_len <= 6'd0;
            r_state  <= S_FILL;
            r_busy   <= 1'b0;
          end
        end
        default: begin
          r_state <= S_FILL;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (w_accept) begin
      r_bank[~r_sel][r_wr_len[IDX_W-1:0]] <= prod.char_in;
    end
  end

`ifdef TEXT_BLINK_EN
  logic [4:0] r_blink_cnt;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_blink_cnt <= 5'd0;
    end else if (frame_start) begin
      r_blink_cnt <= r_blink_cnt + 5'd1;
    end else begin
      r_blink_cnt <= r_blink_cnt;
    end
  end

  assign w_blink_ok = !blink || !r_blink_cnt[4];
`else
  logic w_unused_blink;
  assign w_unused_blink = blink;
  assign w_blink_ok     = 1'b1;
`endif

  // Borrow bit of the 11-bit difference flags pixels left of / above the line.
  always_comb begin
    w_xdiff = {1'b0, DrawX} - {1'b0, X0};
    w_ydiff = {1'b0, DrawY} - {1'b0, Y0};
    w_xlim  = 11'(r_fr_len) << FONT_SH;
    w_in_x  = !w_xdiff[10] && (w_xdiff < w_xlim);
    w_in_y  = !w_ydiff[10] && (w_ydiff[9:0] < FH);
    w_col   = IDX_W'(w_xdiff[9:0] >> FONT_SH);
    w_hit   = active && (r_fr_len != 6'd0) && w_in_x && w_in_y && w_blink_ok;
    if (w_hit) begin
      n = r_bank[r_sel][w_col];
    end else begin
      n = 10'd0;
    end
    is_word = w_hit;
  end

endmodule

// File: tb/tb_text_line_writer.sv
// Self-checking bench for text_line_writer: test-plan vectors, corner-case sequences
// and randomized traffic against a queue-based reference model.
module tb_text_line_writer;

  logic       clk;
  logic       rst_n;
  logic       frame_start;
  logic       blink;
  logic       active;
  logic [9:0] draw_x;
  logic [9:0] draw_y;
  logic [9:0] start_x;
  logic [9:0] start_y;
  logic [9:0] n;
  logic       is_word;

  int errors = 0;
  int checks = 0;

  logic [9:0] m_back[$];
  logic [9:0] m_front[$];
  bit         m_pend;
  int         m_cnt;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic       act;
    logic [9:0] en;
    logic       ew;
  } pix_t;

  pix_t vec[10];

  text_line_writer_if u_if();

  text_line_writer #(
    .MAX_CHARS(16), .X_START(296), .Y_START(232), .FONT_W(8), .FONT_H(16)
  ) dut (
    .Clk(clk), .Reset(rst_n), .prod(u_if.slave), .frame_start(frame_start),
    .blink(blink), .DrawX(draw_x), .DrawY(draw_y), .active(active),
    .start_x(start_x), .start_y(start_y), .n(n), .is_word(is_word)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void m_render(input int x, input int y, input logic a,
                                   output logic [9:0] en, output logic ew);
    int len;
    len = m_front.size();
    ew = 1'b0;
    en = 10'd0;
    if (a && len != 0 && x >= 296 && x < 296 + 8 * len && y >= 232 && y < 232 + 16) begin
      ew = 1'b1;
`ifdef TEXT_BLINK_EN
      if (blink && m_cnt >= 16) ew = 1'b0;
`endif
    end
    if (ew) en = m_front[(x - 296) / 8];
  endfunction

  task automatic cyc();
    logic [9:0] en;
    logic       ew;
    #3;
    m_render(int'(draw_x), int'(draw_y), active, en, ew);
    chk("char_ready", u_if.char_ready, rst_n && !m_pend && m_back.size() < 16);
    chk("busy", u_if.busy, m_pend);
    chk("is_word", is_word, ew);
    chk("n", n, en);
    chk("start_x", start_x, 32'd296);
    chk("start_y", start_y, 32'd232);
    if (!rst_n) begin
      m_back.delete();
      m_front.delete();
      m_pend = 1'b0;
      m_cnt  = 0;
    end else begin
      if (frame_start) m_cnt = (m_cnt + 1) % 32;
      if (u_if.clear) begin
        m_back.delete();
        m_pend = 1'b0;
      end else if (!m_pend) begin
        if (u_if.char_valid && m_back.size() < 16) m_back.push_back(u_if.char_in);
        if (u_if.commit) m_pend = 1'b1;
      end else if (frame_start) begin
        m_front = m_back;
        m_back.delete();
        m_pend = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [9:0] ch, input logic cm,
                        input logic cl, input logic fs);
    u_if.char_valid = v;
    u_if.char_in    = ch;
    u_if.commit     = cm;
    u_if.clear      = cl;
    frame_start     = fs;
  endtask

  task automatic px_chk(input string nm, input logic [9:0] x, input logic [9:0] y,
                        input logic ew, input logic [9:0] en);
    draw_x = x;
    draw_y = y;
    #1;
    chk({nm, "_is_word"}, is_word, ew);
    chk({nm, "_n"}, n, en);
  endtask

  task automatic load_line(input logic [9:0] base, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      set_in(1'b1, base + 10'(i), 1'b0, 1'b0, 1'b0);
      cyc();
    end
    set_in(1'b0, 10'd0, 1'b1, 1'b0, 1'b0); cyc();
    set_in(1'b0, 10'd0, 1'b0, 1'b0, 1'b1); cyc();
    set_in(1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [9:0] glyphs [6];
    glyphs = '{10'h0f, 10'h12, 10'h10, 10'h11, 10'h1d, 10'h3f};
    vec[0] = '{10'd296, 10'd232, 1'b1, 10'h0f, 1'b1};
    vec[1] = '{10'd336, 10'd240, 1'b1, 10'h3f, 1'b1};
    vec[2] = '{10'd344, 10'd240, 1'b1, 10'h00, 1'b0};
    vec[3] = '{10'd295, 10'd232, 1'b1, 10'h00, 1'b0};
    vec[4] = '{10'd303, 10'd247, 1'b1, 10'h0f, 1'b1};
    vec[5] = '{10'd304, 10'd248, 1'b1, 10'h00, 1'b0};
    vec[6] = '{10'd304, 10'd231, 1'b1, 10'h00, 1'b0};
    vec[7] = '{10'd312, 10'd240, 1'b1, 10'h10, 1'b1};
    vec[8] = '{10'd343, 10'd235, 1'b1, 10'h3f, 1'b1};
    vec[9] = '{10'd336, 10'd240, 1'b0, 10'h00, 1'b0};

    rst_n = 1'b0; blink = 1'b0; active = 1'b1; draw_x = 10'd296; draw_y = 10'd232;
    set_in(1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    cyc(); cyc();
    chk("reset_ready", u_if.char_ready, 32'd0);
    rst_n = 1'b1;
    #1 chk("ready_after_release", u_if.char_ready, 32'd1);
    cyc();

    // Test-plan line
    for (int i = 0; i < 6; i++) begin
      set_in(1'b1, glyphs[i], 1'b0, 1'b0, 1'b0); cyc();
    end
    set_in(1'b0, 10'd0, 1'b1, 1'b0, 1'b0); cyc();
    set_in(1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("busy_pending", u_if.busy, 32'd1);
      cyc();
    end
    frame_start = 1'b1; cyc(); frame_start = 1'b0;
    #1 chk("busy_after_swap", u_if.busy, 32'd0);
    for (int i = 0; i < 10; i++) begin
      draw_x = vec[i].x; draw_y = vec[i].y; active = vec[i].act;
      #1;
      chk($sformatf("tbl%0d_n", i), n, vec[i].en);
      chk($sformatf("tbl%0d_is_word", i), is_word, vec[i].ew);
      cyc();
    end
    active = 1'b1;

    // Fill to capacity, 17th glyph refused
    set_in(1'b0, 10'd0, 1'b0, 1'b1, 1'b0); cyc();
    for (int i = 0; i < 17; i++) begin
      set_in(1'b1, 10'h20 + 10'(i), 1'b0, 1'b0, 1'b0);
      #1 chk($sformatf("full_ready%0d", i), u_if.char_ready, (i < 16) ? 32'd1 : 32'd0);
      cyc();
    end
    set_in(1'b0, 10'd0, 1'b1, 1'b0, 1'b0); cyc();
    set_in(1'b0, 10'd0, 1'b0, 1'b0, 1'b1); cyc();
    set_in(1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    px_chk("full_last", 10'd416, 10'd232, 1'b1, 10'h2f);
    px_chk("full_end", 10'd424, 10'd232, 1'b0, 10'h00);
    cyc();

    // commit + clear together
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 10'h30 + 10'(i), 1'b0, 1'b0, 1'b0); cyc();
    end
    set_in(1'b1, 10'h33, 1'b1, 1'b1, 1'b0); cyc();
    set_in(1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    #1 chk("cc_busy", u_if.busy, 32'd0);
    px_chk("cc_front", 10'd296, 10'd232, 1'b1, 10'h20);
    cyc();

    // commit + frame_start together: swap deferred
    set_in(1'b1, 10'h01, 1'b0, 1'b0, 1'b0); cyc();
    set_in(1'b1, 10'h02, 1'b0, 1'b0, 1'b0); cyc();
    set_in(1'b0, 10'd0, 1'b1, 1'b0, 1'b1); cyc();
    set_in(1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    #1 chk("cf_busy", u_if.busy, 32'd1);
    px_chk("cf_old_front", 10'd296, 10'd232, 1'b1, 10'h20);
    cyc();
    frame_start = 1'b1; cyc(); frame_start = 1'b0;
    px_chk("cf_new0", 10'd296, 10'd232, 1'b1, 10'h01);
    px_chk("cf_new1", 10'd304, 10'd232, 1'b1, 10'h02);
    px_chk("cf_end", 10'd312, 10'd232, 1'b0, 10'h00);
    cyc();

    // Empty commit
    load_line(10'h00, 0);
    for (int x = 280; x < 440; x += 4) begin
      draw_x = 10'(x); draw_y = 10'd240; cyc();
    end
    px_chk("empty", 10'd296, 10'd232, 1'b0, 10'h00);
    cyc();

    // active low over a loaded line
    load_line(10'h0a, 3);
    active = 1'b0;
    px_chk("inactive", 10'd296, 10'd232, 1'b0, 10'h00);
    cyc();
    active = 1'b1;
    px_chk("active", 10'd296, 10'd232, 1'b1, 10'h0a);
    cyc();

    // Blink over 32 frames
    blink = 1'b1; draw_x = 10'd300; draw_y = 10'd240;
    for (int k = 0; k < 32; k++) begin
      frame_start = 1'b1; cyc(); frame_start = 1'b0;
      #1;
`ifdef TEXT_BLINK_EN
      chk($sformatf("blink%0d", k), is_word, (m_cnt < 16) ? 32'd1 : 32'd0);
`else
      chk($sformatf("blink%0d", k), is_word, 32'd1);
`endif
      cyc();
    end
    blink = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      set_in(1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)),
             ($urandom_range(0, 19) == 0), ($urandom_range(0, 49) == 0),
             ($urandom_range(0, 9) == 0));
      active = ($urandom_range(0, 9) != 0);
      blink  = ($urandom_range(0, 3) == 0);
      draw_x = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(0, 1023))
                                           : 10'($urandom_range(280, 440));
      draw_y = 10'($urandom_range(224, 256));
      cyc();
    end
    set_in(1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    blink = 1'b0; active = 1'b1;

    // Reset during PEND
    load_line(10'h15, 2);
    set_in(1'b1, 10'h19, 1'b0, 1'b0, 1'b0); cyc();
    set_in(1'b0, 10'd0, 1'b1, 1'b0, 1'b0); cyc();
    set_in(1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    #1 chk("rp_busy_before", u_if.busy, 32'd1);
    rst_n = 1'b0; cyc();
    rst_n = 1'b1;
    #1 chk("rp_busy_after", u_if.busy, 32'd0);
    px_chk("rp_blank", 10'd296, 10'd232, 1'b0, 10'h00);
    cyc();
    frame_start = 1'b1; cyc(); frame_start = 1'b0;
    px_chk("rp_no_swap", 10'd296, 10'd232, 1'b0, 10'h00);
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/text_line_writer.md
# text_line_writer

Runtime-loadable single-line text source for the VGA text overlay. A game-logic producer streams font glyph codes in over a valid/ready handshake, and the block stores them in a back buffer. On commit, the back buffer is swapped to the front at the next frame boundary. The render side presents the same DrawX/DrawY to `start_x`/`start_y`/`n`/`is_word` interface as the fixed banner words, so the existing font ROM and colour mapper consume it unchanged.

## Interface
- `MAX_CHARS`, 16: buffer depth in characters per bank (≤ 32).
- `X_START`, 0: left pixel column of the line.
- `Y_START`, 0: top pixel row of the line.
- `FONT_W`, 8: glyph width in pixels; must be a power of two.
- `FONT_H`, 16: glyph height in pixels.

Ports:
- `Clk`  in  1  system/pixel clock; all state on rising edge.
- `Reset`  in  1  synchronous, active-low reset.
- `char_in`  in  10  glyph code, same encoding as `n` (e.g. 0x0a=A, 0x3f=!).
- `char_valid`  in  1  producer has a glyph on `char_in`.
- `char_ready`  out  1  block accepts a glyph this cycle.
- `commit`  in  1  one-cycle pulse: publish the back buffer.
- `clear`  in  1  one-cycle pulse: empty the back buffer / cancel a pending commit.
- `frame_start`  in  1  one-cycle pulse at vertical blank.
- `blink`  in  1  blink request; used only with `TEXT_BLINK_EN`.
- `DrawX`, `DrawY`  in  10  current pixel.
- `active`  in  1  overlay enable.
- `start_x`, `start_y`  out  10  constant `X_START`, `Y_START`.
- `n`  out  10  glyph code under the current pixel.
- `is_word`  out  1  current pixel lies inside the displayed line.
- `busy`  out  1  commit pending (state PEND).

## Operation
- Storage: two banks of `MAX_CHARS` × 10 bits. `sel` names the front bank. `wr_len` is the back fill count and `fr_len` is the front length; each is 6 bits.
- State FILL:
  - `char_ready = (wr_len < MAX_CHARS)`.
  - A handshake (`char_valid && char_ready`) writes `back[wr_len] <= char_in` and increments `wr_len`.
- FILL → PEND on `commit`. A glyph accepted in the same cycle is included in the commit.
- State PEND:
  - `char_ready = 0`, `busy = 1`.
  - On `frame_start`: toggle `sel`, set `fr_len <= wr_len` and `wr_len <= 0`, then → FILL.
  - The new back bank holds the old front's contents, which are treated as garbage.
- Commit at full capacity is legal. Commit with `wr_len = 0` is legal: it publishes an empty line and `is_word` then stays 0.
- `clear`:
  - Sets `wr_len <= 0`; any state → FILL.
  - Has priority over `commit`, `frame_start` and handshakes in the same cycle; a glyph offered in that cycle is not accepted.
- `commit` in PEND is ignored.
- `frame_start` in FILL has no effect. `commit` + `frame_start` in the same FILL cycle → PEND only; the swap happens at the next `frame_start`.
- Render path (combinational):
  - `is_word = active && fr_len != 0 && DrawX ∈ [X_START, X_START + fr_len*FONT_W) && DrawY ∈ [Y_START, Y_START + FONT_H)`.
  - `n = front[(DrawX - X_START) / FONT_W]` when `is_word`, else 0.
  - Comparisons use 10-bit unsigned arithmetic. The subtraction is evaluated only inside the window, so no wrap-around is exposed.

## Timing
- Reset values: state FILL, `sel = 0`, `wr_len = 0`, `fr_len = 0`, `busy = 0`, `n = 0`, `is_word = 0`, blink counter 0. `char_ready` is 0 while `Reset` is low and 1 in the first cycle after release.
- Write latency: a glyph accepted at edge k is in the back bank after edge k.
- Commit: `busy` rises the cycle after `commit`. At the `frame_start` edge, `busy` falls and the new text drives `n`/`is_word` from the next cycle.
- `char_ready` falls combinationally when `wr_len` reaches `MAX_CHARS`.
- Render outputs have zero latency relative to DrawX/DrawY, identical to the fixed banner words.
- A reset asserted mid-PEND discards the pending commit and blanks the display.

## Configuration
- `TEXT_BLINK_EN` defined:
  - A 5-bit counter increments on each `frame_start`.
  - When `blink = 1`, `is_word` is additionally gated by counter bit 4 (16 frames on, 16 off).
  - The counter resets to 0.
- `TEXT_BLINK_EN` undefined: no counter is built, `blink` is ignored, and `is_word` is never gated.

## Test plan
- Reset, then stream 0x0f,0x12,0x10,0x11,0x1d,0x3f, commit, then pulse `frame_start`:
  - `busy` is 1 until the pulse.
  - Afterwards, with X_START=296 and Y_START=232, pixel (296,232) → n=0x0f, is_word=1.
  - Pixel (336,240) → n=0x3f.
  - Pixel (344,240) → is_word=0.
- Write 16 glyphs with `char_valid` held high: `char_ready` drops after the 16th, and a 17th offered glyph is not stored.
- `commit` and `clear` in the same cycle: state stays FILL, `busy` = 0, `wr_len` = 0, and the front display is unchanged.
- `commit` and `frame_start` in the same cycle: no swap. The swap occurs on the following `frame_start`.
- Commit with zero glyphs, then `frame_start`: `is_word` = 0 everywhere. Separately, drive `active = 0` over a loaded line → `is_word` = 0.
- With `TEXT_BLINK_EN` defined and `blink = 1`, pulse `frame_start` 32 times: `is_word` in-window is high for frames 0–15 and low for frames 16–31.
